// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter and busy scoreboard for a 32x32 register file
//   clk, rst (async, active-low)
//   req0_* : ALU write-back request (valid/addr/data in, ready out, combinational grant)
//   req1_* : load write-back request (valid/addr/data in, ready out, combinational grant)
//   rsv_valid/rsv_addr : issue-stage destination reservation (sets a busy bit)
//   Read_addr_1/2 -> busy_1/2 : outstanding-write status of issue-stage sources
//   fwd_1/2 : only when WB_FWD_EN is defined; operand available from Write_data
//   RegWrite/Write_addr/Write_data : registered register-file write port
module regfile_wb_arbiter #(
    parameter int bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [4:0]          req0_addr,
    input  logic [bit_size-1:0] req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [4:0]          req1_addr,
    input  logic [bit_size-1:0] req1_data,
    output logic                req1_ready,
    input  logic                rsv_valid,
    input  logic [4:0]          rsv_addr,
    input  logic [4:0]          Read_addr_1,
    input  logic [4:0]          Read_addr_2,
    output logic                busy_1,
    output logic                busy_2,
`ifdef WB_FWD_EN
    output logic                fwd_1,
    output logic                fwd_2,
`endif
    output logic                RegWrite,
    output logic [4:0]          Write_addr,
    output logic [bit_size-1:0] Write_data
);

    logic                last_grant_q, last_grant_d;
    logic                regwrite_q, regwrite_d;
    logic [4:0]          write_addr_q, write_addr_d;
    logic [bit_size-1:0] write_data_q, write_data_d;
    logic [31:0]         busy_q, busy_d;
    logic                xfer;
    logic [4:0]          xfer_addr;
    logic [bit_size-1:0] xfer_data;

    always_comb begin
        // On contention the requester that did not win last time is granted.
        req0_ready   = rst && req0_valid && (!req1_valid || last_grant_q);
        req1_ready   = rst && req1_valid && (!req0_valid || !last_grant_q);
        xfer         = req0_ready || req1_ready;
        xfer_addr    = req0_ready ? req0_addr : req1_addr;
        xfer_data    = req0_ready ? req0_data : req1_data;
        last_grant_d = xfer ? req1_ready : last_grant_q;
        // r0 is hardwired: accept the transfer but never write it.
        regwrite_d   = xfer && (xfer_addr != 5'd0);
        write_addr_d = xfer ? xfer_addr : write_addr_q;
        write_data_d = xfer ? xfer_data : write_data_q;
        busy_d       = busy_q;
        if (xfer)
            busy_d[xfer_addr] = 1'b0;
        // A reservation on the same edge is newer than the completing write.
        if (rsv_valid)
            busy_d[rsv_addr] = 1'b1;
        busy_d[0]    = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
            regwrite_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            regwrite_q   <= regwrite_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    assign RegWrite   = regwrite_q;
    assign Write_addr = write_addr_q;
    assign Write_data = write_data_q;

`ifdef WB_FWD_EN
    // The write on the outputs this cycle supplies the operand directly.
    assign fwd_1  = regwrite_q && (write_addr_q == Read_addr_1) && (write_addr_q != 5'd0);
    assign fwd_2  = regwrite_q && (write_addr_q == Read_addr_2) && (write_addr_q != 5'd0);
    assign busy_1 = busy_q[Read_addr_1] && !fwd_1;
    assign busy_2 = busy_q[Read_addr_2] && !fwd_2;
`else
    assign busy_1 = busy_q[Read_addr_1];
    assign busy_2 = busy_q[Read_addr_2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr = '0;
    logic [31:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr = '0;
    logic [31:0] req1_data = '0;
    logic        req1_ready;
    logic        rsv_valid = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic [4:0]  Read_addr_1 = '0;
    logic [4:0]  Read_addr_2 = '0;
    logic        busy_1, busy_2;
`ifdef WB_FWD_EN
    logic        fwd_1, fwd_2;
`endif
    logic        RegWrite;
    logic [4:0]  Write_addr;
    logic [31:0] Write_data;

    int          compared = 0;
    int          mismatched = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;

    regfile_wb_arbiter #(.bit_size(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .Read_addr_1(Read_addr_1), .Read_addr_2(Read_addr_2),
        .busy_1(busy_1), .busy_2(busy_2),
`ifdef WB_FWD_EN
        .fwd_1(fwd_1), .fwd_2(fwd_2),
`endif
        .RegWrite(RegWrite), .Write_addr(Write_addr), .Write_data(Write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write-back pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && RegWrite) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL wb_unexpected: got write r%0d=%h, required no write", Write_addr, Write_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_addr", {27'd0, Write_addr}, {27'd0, mon_e[36:32]});
                chk("wb_data", Write_data, mon_e[31:0]);
            end
        end
    end

    logic [31:0] d0[3];
    logic [31:0] d1[3];
    bit          g[4];
    int          i0, i1;

    initial begin
        d0 = '{32'h11, 32'h12, 32'h13};
        d1 = '{32'h21, 32'h22, 32'h23};
        g  = '{1'b0, 1'b1, 1'b0, 1'b1};
        // reset state
        req0_valid = 1'b1;
        #3;
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_waddr", {27'd0, Write_addr}, 32'd0);
        chk("rst_wdata", Write_data, 32'd0);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        // single write r5
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h1234_5678;
        #1;
        chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
        chk("t1_ready1", {31'd0, req1_ready}, 32'd0);
        exp_q.push_back({5'd5, 32'h1234_5678});
        step();
        req0_valid = 1'b0;
        chk("t1_regwrite", {31'd0, RegWrite}, 32'd1);
        // req1 alone so that req0 wins the next contention
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hA0;
        #1;
        chk("t2_pre_ready1", {31'd0, req1_ready}, 32'd1);
        exp_q.push_back({5'd2, 32'hA0});
        step();
        // contention: grants alternate 0,1,0,1
        i0 = 0; i1 = 0;
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1'b1; req0_addr = 5'd1; req0_data = d0[i0];
            req1_valid = 1'b1; req1_addr = 5'd2; req1_data = d1[i1];
            #1;
            chk("t2_ready0", {31'd0, req0_ready}, {31'd0, !g[k]});
            chk("t2_ready1", {31'd0, req1_ready}, {31'd0, g[k]});
            chk("t2_streak", {31'd0, RegWrite}, 32'd1);
            if (g[k]) begin
                exp_q.push_back({5'd2, d1[i1]});
                i1++;
            end else begin
                exp_q.push_back({5'd1, d0[i0]});
                i0++;
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t2_streak_end", {31'd0, RegWrite}, 32'd1);
        // reserve r7, complete it via req1
        rsv_valid = 1'b1; rsv_addr = 5'd7; Read_addr_1 = 5'd7; Read_addr_2 = 5'd3;
        #1;
        chk("t3_busy_before", {31'd0, busy_1}, 32'd0);
        step();
        rsv_valid = 1'b0;
        chk("t3_busy_set", {31'd0, busy_1}, 32'd1);
        chk("t3_busy_other", {31'd0, busy_2}, 32'd0);
        step();
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
        #1;
        chk("t3_ready1", {31'd0, req1_ready}, 32'd1);
        chk("t3_busy_xfer", {31'd0, busy_1}, 32'd1);
        exp_q.push_back({5'd7, 32'h77});
        step();
        req1_valid = 1'b0;
        chk("t3_busy_clear", {31'd0, busy_1}, 32'd0);
`ifdef WB_FWD_EN
        chk("t3_fwd_1", {31'd0, fwd_1}, 32'd1);
`endif
        // r9: reservation on the same edge as its completing write
        rsv_valid = 1'b1; rsv_addr = 5'd9; Read_addr_2 = 5'd9;
        step();
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        #1;
        chk("t4_ready0", {31'd0, req0_ready}, 32'd1);
        exp_q.push_back({5'd9, 32'h99});
        step();
        req0_valid = 1'b0; rsv_valid = 1'b0;
`ifdef WB_FWD_EN
        chk("t4_fwd_2", {31'd0, fwd_2}, 32'd1);
        chk("t4_busy_fwd", {31'd0, busy_2}, 32'd0);
`else
        chk("t4_busy_wb", {31'd0, busy_2}, 32'd1);
`endif
        step();
        chk("t4_busy_kept", {31'd0, busy_2}, 32'd1);
        // r0 write and reservation are both no-ops
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFF_FFFF;
        rsv_valid = 1'b1; rsv_addr = 5'd0; Read_addr_1 = 5'd0;
        #1;
        chk("t5_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0; rsv_valid = 1'b0;
        chk("t5_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("t5_busy_r0", {31'd0, busy_1}, 32'd0);
        step();
        // reset while req1 waits and r3 is busy
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
        rsv_valid = 1'b1; rsv_addr = 5'd3; Read_addr_1 = 5'd3;
        #1;
        chk("t6_ready1", {31'd0, req1_ready}, 32'd1);
        exp_q.push_back({5'd4, 32'h44});
        step();
        rsv_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hAAAA_0010;
        req1_addr = 5'd11; req1_data = 32'hBBBB_0011;
        #1;
        chk("t6_busy3", {31'd0, busy_1}, 32'd1);
        chk("t6_c_ready0", {31'd0, req0_ready}, 32'd1);
        chk("t6_c_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("t6_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("t6_rst_waddr", {27'd0, Write_addr}, 32'd0);
        chk("t6_rst_wdata", Write_data, 32'd0);
        chk("t6_rst_busy", {31'd0, busy_1}, 32'd0);
        chk("t6_rst_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk("t6_post_ready0", {31'd0, req0_ready}, 32'd1);
        chk("t6_post_ready1", {31'd0, req1_ready}, 32'd0);
        chk("t6_post_busy", {31'd0, busy_1}, 32'd0);
        exp_q.push_back({5'd10, 32'hAAAA_0010});
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        step();
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
